spi_word_slave: RTL and testbench
=================================

SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 The block SHALL have: clk  input  1  system clock; all logic in this domain.
REQ-002 The block SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have: spi_sclk  input  1  SPI clock from host, mode 0, at most clk/4.
REQ-004 The block SHALL have: spi_cs_n  input  1  SPI chip select, active low.
REQ-005 The block SHALL have: spi_mosi  input  1  host-to-device serial data, MSB first.
REQ-006 The block SHALL have: spi_miso  output  1  device-to-host serial status, MSB first.
REQ-007 The block SHALL have: spi_data  output  16  last complete received word ([15] eop, [14] valid, [7:0] byte).
REQ-008 The block SHALL have: spi_data_strobe  output  1  level pulse, high when a new spi_data is presented.
REQ-009 The block SHALL have: spi_data_request  input  1  downstream transmitter wants a word.
REQ-010 The block SHALL have: underflow, overflow  input  1 each  downstream error flags, reported in status.
REQ-011 The block SHALL have: framing_error  output  1  sticky: CS deasserted mid-word.

Function
REQ-012 spi_sclk, spi_cs_n and spi_mosi SHALL each pass a 2-flop synchronizer; edges SHALL be detected on the synchronized sclk.
REQ-013 FSM states SHALL be IDLE, SHIFT, STROBE: IDLE->SHIFT on synchronized cs_n falling; SHIFT->STROBE after the 16th sclk rise; STROBE->SHIFT after 2 clk cycles; any state->IDLE on cs_n high.
REQ-014 On cs_n falling the block SHALL capture the 16-bit status word into a shadow register, clear the bit counter, and drive status[15] on spi_miso.
REQ-015 On each synchronized sclk rise in SHIFT the block SHALL shift spi_mosi into the receive register LSB end and increment a 4-bit bit counter.
REQ-016 On each synchronized sclk fall the block SHALL advance spi_miso to the next status bit; after bit 0, spi_miso SHALL be 0.
REQ-017 On the 16th rise (counter wraps 15->0) spi_data SHALL load the receive register on the next clk edge and spi_data_strobe SHALL be high exactly 2 clk cycles, then low at least 1 cycle.
REQ-018 spi_data SHALL hold its value until the next complete word; partial words SHALL never update it.
REQ-019 Multiple words per CS assertion SHALL be supported; the status shadow SHALL be recaptured at each word boundary.
REQ-020 Status word SHALL be: [15] spi_data_request, [14] underflow, [13] overflow, [12] framing_error, [11:8] version 4'h1, [7:0] per REQ-026.
REQ-021 cs_n rising with bit counter non-zero SHALL set framing_error and discard the partial word; no strobe SHALL be produced.
REQ-022 framing_error SHALL clear when a complete status word containing it set has been shifted out; a new set in the same cycle SHALL take priority.
REQ-023 A word boundary coinciding with cs_n rising SHALL be treated as complete (strobe produced, no framing error).

Reset
REQ-024 During reset: spi_data=16'h0000, spi_data_strobe=0, spi_miso=0, framing_error=0, FSM=IDLE, counter=0, synchronizers reset to idle levels (sclk 0, cs_n 1, mosi 0).
REQ-025 Reset asserted mid-word SHALL discard the partial word with no strobe and no framing_error.

Configuration
REQ-026 With SPI_WORD_COUNT_EN defined, status[7:0] SHALL be a mod-256 count of complete words received since reset; without it status[7:0] SHALL be 8'h00 and no counter SHALL exist.

Structure
REQ-027 Shared package eb3_spi_pkg SHALL hold: word width 16, bit indices EOP=15 and VALID=14, status bit indices, version constant 4'h1, FSM state typedef.
REQ-028 One sub-module, sync2 (2-flop synchronizer with reset value parameter), SHALL be instantiated three times.

Verification
REQ-029 One word 16'hC05A, sclk=clk/8 -> spi_data=16'hC05A, strobe high exactly 2 cycles, one strobe.
REQ-030 Request=1, underflow=0, overflow=1, count=3 (macro on) -> MISO reads 16'hA103; macro off -> 16'hA100.
REQ-031 cs_n released after 9 bits -> no strobe, spi_data unchanged, framing_error=1; next status read bit12=1, read after that bit12=0.
REQ-032 Three back-to-back words 16'h4011, 16'h4022, 16'hC033 in one CS -> three strobes, values in order, count +3.
REQ-033 Reset asserted after 10 bits -> all outputs at reset values; subsequent full word 16'h4077 received correctly.
REQ-034 Word completes in same clk as cs_n rise -> strobe produced, framing_error stays 0.

Source files
------------

// File: rtl/eb3_spi_pkg.sv
// +----------------------------------------------------------------------+
// | eb3_spi_pkg -- shared widths, bit indices and FSM states for SPI.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package eb3_spi_pkg;

  localparam int WORD_W = 16;

  // Received word layout
  localparam int EOP_BIT   = 15;
  localparam int VALID_BIT = 14;

  // Status word layout
  localparam int ST_REQ_BIT    = 15;
  localparam int ST_UNDER_BIT  = 14;
  localparam int ST_OVER_BIT   = 13;
  localparam int ST_FE_BIT     = 12;
  localparam int ST_VER_HI     = 11;
  localparam int ST_VER_LO     = 8;
  localparam int ST_CNT_HI     = 7;
  localparam int ST_CNT_LO     = 0;

  localparam logic [3:0] VERSION = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_STROBE = 2'd2
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_word_slave_sync2.sv
// +----------------------------------------------------------------------+
// | sync2 -- two-flop synchronizer with configurable reset level.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/spi_word_slave.sv
// +----------------------------------------------------------------------+
// | spi_word_slave -- SPI mode-0 16-bit word slave with status readback. |
// | Rev 1.0; SPI_WORD_COUNT_EN adds a word counter to status[7:0].       |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_word_slave
  import eb3_spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [WORD_W-1:0] spi_data,
  output logic              spi_data_strobe,
  input  logic              spi_data_request,
  input  logic              underflow,
  input  logic              overflow,
  output logic              framing_error
);

  logic sclk_s, cs_n_s, mosi_s;

  sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_cs_n (.clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_n_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s));

  spi_state_e        state_q, state_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic              cs_n_prev_q, cs_n_prev_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              fe_q, fe_d;
  logic              fe_shadow_q, fe_shadow_d;
  logic              strobe_cnt_q, strobe_cnt_d;
`ifdef SPI_WORD_COUNT_EN
  logic [7:0]        word_cnt_q, word_cnt_d;
`endif

  logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic              shift_en, fall_en, word_done;
  logic [WORD_W-1:0] rx_next;
  logic [WORD_W-1:0] status_w;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;
  // Edges are honoured only while CS was low, so a rise landing together
  // with CS release still completes the word.
  assign shift_en  = (state_q != ST_IDLE) && sclk_rise && !cs_n_prev_q;
  assign fall_en   = (state_q != ST_IDLE) && sclk_fall && !cs_n_prev_q;
  assign word_done = shift_en && (bit_cnt_q == 4'hF);
  assign rx_next   = {rx_q[WORD_W-2:0], mosi_s};

  always_comb begin
    status_w                       = '0;
    status_w[ST_REQ_BIT]           = spi_data_request;
    status_w[ST_UNDER_BIT]         = underflow;
    status_w[ST_OVER_BIT]          = overflow;
    status_w[ST_FE_BIT]            = fe_q;
    status_w[ST_VER_HI:ST_VER_LO]  = VERSION;
`ifdef SPI_WORD_COUNT_EN
    status_w[ST_CNT_HI:ST_CNT_LO]  = word_cnt_q;
`endif
  end

  always_comb begin
    state_d      = state_q;
    sclk_prev_d  = sclk_s;
    cs_n_prev_d  = cs_n_s;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    data_d       = data_q;
    fe_d         = fe_q;
    fe_shadow_d  = fe_shadow_q;
    strobe_cnt_d = strobe_cnt_q;
`ifdef SPI_WORD_COUNT_EN
    word_cnt_d   = word_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_SHIFT;
          bit_cnt_d   = 4'd0;
          tx_d        = status_w;
          fe_shadow_d = fe_q;
        end
      end
      default: begin
        // The strobe always runs its full two cycles, even if CS has gone.
        if (state_q == ST_STROBE) begin
          if (strobe_cnt_q) state_d = cs_n_s ? ST_IDLE : ST_SHIFT;
          else              strobe_cnt_d = 1'b1;
        end else if (cs_n_s) begin
          state_d = ST_IDLE;
        end

        if (shift_en) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end

        if (word_done) begin
          data_d       = rx_next;
          state_d      = ST_STROBE;
          strobe_cnt_d = 1'b0;
`ifdef SPI_WORD_COUNT_EN
          word_cnt_d   = word_cnt_q + 8'd1;
`endif
          if (fe_shadow_q) begin
            fe_d        = 1'b0;
            fe_shadow_d = 1'b0;
          end
        end else if (fall_en) begin
          // The fall after a word boundary presents the next word's MSB.
          if (bit_cnt_q == 4'd0) begin
            tx_d        = status_w;
            fe_shadow_d = fe_q;
          end else begin
            tx_d = {tx_q[WORD_W-2:0], 1'b0};
          end
        end

        if (cs_rise && !word_done && ((bit_cnt_q != 4'd0) || shift_en)) begin
          fe_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sclk_prev_q  <= 1'b0;
      cs_n_prev_q  <= 1'b1;
      bit_cnt_q    <= 4'd0;
      rx_q         <= '0;
      tx_q         <= '0;
      data_q       <= '0;
      fe_q         <= 1'b0;
      fe_shadow_q  <= 1'b0;
      strobe_cnt_q <= 1'b0;
`ifdef SPI_WORD_COUNT_EN
      word_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_n_prev_q  <= cs_n_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      data_q       <= data_d;
      fe_q         <= fe_d;
      fe_shadow_q  <= fe_shadow_d;
      strobe_cnt_q <= strobe_cnt_d;
`ifdef SPI_WORD_COUNT_EN
      word_cnt_q   <= word_cnt_d;
`endif
    end
  end

  assign spi_miso        = (state_q != ST_IDLE) && !cs_n_prev_q && tx_q[WORD_W-1];
  assign spi_data        = data_q;
  assign spi_data_strobe = (state_q == ST_STROBE);
  assign framing_error   = fe_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_word_slave.sv
// +----------------------------------------------------------------------+
// | tb_spi_word_slave -- directed vectors for spi_word_slave, sclk=clk/8.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_spi_word_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] spi_data;
  logic        spi_data_strobe;
  logic        spi_data_request = 1'b0;
  logic        underflow = 1'b0;
  logic        overflow = 1'b0;
  logic        framing_error;

  spi_word_slave dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_data(spi_data), .spi_data_strobe(spi_data_strobe),
    .spi_data_request(spi_data_request), .underflow(underflow), .overflow(overflow),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;
  int words = 0;
  logic [15:0] strobe_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cnt_byte(input int n);
    logic [31:0] v;
    v = n;
`ifdef SPI_WORD_COUNT_EN
    return v[7:0];
`else
    return 8'h00;
`endif
  endfunction

  // Strobe monitor: pulse count, captured words, and exact 2-cycle width.
  initial begin
    int  run = 0;
    logic prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (spi_data_strobe) begin
        if (!prev) begin
          strobes++;
          strobe_words.push_back(spi_data);
        end
        run++;
      end else if (prev) begin
        check("strobe_width", run, 2);
        run = 0;
      end
      prev = spi_data_strobe;
    end
  end

  task automatic spi_bits(input logic [15:0] w, input int n, input bit coincide,
                          output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[15-i];
      tick(4);
      got = {got[14:0], spi_miso};
      spi_sclk = 1'b1;
      if (coincide && i == n - 1) spi_cs_n = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic xact(input logic [15:0] w, output logic [15:0] got);
    cs_lo();
    spi_bits(w, 16, 1'b0, got);
    tick(4);
    cs_hi();
  endtask

  typedef struct {
    logic [15:0] word;
    logic        req;
    logic        und;
    logic        ovf;
    logic [7:0]  st_hi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] got, g1, g2, g3;
    int s0, q0;

    vecs[0] = '{word: 16'hC05A, req: 1'b0, und: 1'b0, ovf: 1'b0, st_hi: 8'h01};
    vecs[1] = '{word: 16'h1234, req: 1'b1, und: 1'b1, ovf: 1'b0, st_hi: 8'hC1};
    vecs[2] = '{word: 16'hFFFF, req: 1'b0, und: 1'b0, ovf: 1'b1, st_hi: 8'h21};
    vecs[3] = '{word: 16'h0000, req: 1'b1, und: 1'b0, ovf: 1'b1, st_hi: 8'hA1};
    vecs[4] = '{word: 16'h8001, req: 1'b0, und: 1'b1, ovf: 1'b1, st_hi: 8'h61};

    tick(3);
    check("reset_data", spi_data, 16'h0000);
    check("reset_strobe", spi_data_strobe, 1'b0);
    check("reset_miso", spi_miso, 1'b0);
    check("reset_fe", framing_error, 1'b0);
    reset = 1'b0;
    tick(4);

    // Single-word transactions with varied status inputs
    for (int v = 0; v < 5; v++) begin
      spi_data_request = vecs[v].req;
      underflow        = vecs[v].und;
      overflow         = vecs[v].ovf;
      s0 = strobes;
      xact(vecs[v].word, got);
      check("vec_miso", got, {vecs[v].st_hi, cnt_byte(words)});
      words++;
      check("vec_data", spi_data, vecs[v].word);
      check("vec_strobes", strobes - s0, 1);
    end
    spi_data_request = 1'b0;
    underflow        = 1'b0;
    overflow         = 1'b0;

    // CS released after 9 bits: framing error, no update
    s0 = strobes;
    cs_lo();
    spi_bits(16'hABCD, 9, 1'b0, got);
    tick(4);
    cs_hi();
    check("frame_strobes", strobes - s0, 0);
    check("frame_data", spi_data, 16'h8001);
    check("frame_fe", framing_error, 1'b1);
    xact(16'h1111, got);
    check("frame_status1", got, {8'h11, cnt_byte(words)});
    words++;
    check("frame_fe_clear", framing_error, 1'b0);
    xact(16'h2222, got);
    check("frame_status2", got, {8'h01, cnt_byte(words)});
    words++;

    // Three back-to-back words in one CS
    s0 = strobes;
    q0 = strobe_words.size();
    cs_lo();
    spi_bits(16'h4011, 16, 1'b0, g1);
    spi_bits(16'h4022, 16, 1'b0, g2);
    spi_bits(16'hC033, 16, 1'b0, g3);
    tick(4);
    cs_hi();
    check("b2b_strobes", strobes - s0, 3);
    if (strobes - s0 == 3) begin
      check("b2b_w0", strobe_words[q0], 16'h4011);
      check("b2b_w1", strobe_words[q0+1], 16'h4022);
      check("b2b_w2", strobe_words[q0+2], 16'hC033);
    end
    check("b2b_st0", g1, {8'h01, cnt_byte(words)});
    check("b2b_st1", g2, {8'h01, cnt_byte(words + 1)});
    check("b2b_st2", g3, {8'h01, cnt_byte(words + 2)});
    words += 3;

    // Reset in the middle of a word
    s0 = strobes;
    cs_lo();
    spi_bits(16'h5555, 10, 1'b0, got);
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    tick(3);
    check("midrst_data", spi_data, 16'h0000);
    check("midrst_strobe", spi_data_strobe, 1'b0);
    check("midrst_miso", spi_miso, 1'b0);
    check("midrst_fe", framing_error, 1'b0);
    reset = 1'b0;
    words = 0;
    tick(4);
    xact(16'h4077, got);
    check("midrst_status", got, {8'h01, cnt_byte(words)});
    words++;
    check("midrst_word", spi_data, 16'h4077);
    check("midrst_strobes", strobes - s0, 1);

    // Last rise coincides with CS release
    s0 = strobes;
    cs_lo();
    spi_bits(16'h3C3C, 16, 1'b1, got);
    tick(8);
    check("coin_status", got, {8'h01, cnt_byte(words)});
    words++;
    check("coin_strobes", strobes - s0, 1);
    check("coin_data", spi_data, 16'h3C3C);
    check("coin_fe", framing_error, 1'b0);
    xact(16'h0F0F, got);
    check("coin_next_status", got, {8'h01, cnt_byte(words)});
    check("coin_next_data", spi_data, 16'h0F0F);

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
